// File: rtl/irq_ctrl_pkg.sv
// Shared register offsets, limits and types for the interrupt controller.
package irq_ctrl_pkg;

   localparam logic [1:0] REG_STATUS = 2'd0;
   localparam logic [1:0] REG_MASK   = 2'd1;
   localparam logic [1:0] REG_ID     = 2'd2;
   localparam logic [1:0] REG_CFG    = 2'd3;

   localparam int unsigned NSRC_MAX     = 8;
   localparam int unsigned ID_VALID_BIT = 7;

   typedef logic [2:0] irq_idx_t;

endpackage

// File: rtl/irq_ctrl_prio_enc.sv
// Lowest-index-first priority encoder; index 0 is the highest priority.
//  req_i     : request vector
//  valid_c_o : any request set (combinational)
//  idx_c_o   : lowest set index, 0 when none (combinational)
module irq_prio_enc
   import irq_ctrl_pkg::*;
#(
   parameter int unsigned NSRC = 4
) (
   input  logic [NSRC-1:0] req_i,
   output logic            valid_c_o,
   output irq_idx_t        idx_c_o
);

   // Scan from the top down so the lowest set index is written last.
   always_comb begin
      valid_c_o = |req_i;
      idx_c_o   = '0;
      for (int i = int'(NSRC) - 1; i >= 0; i--) begin
         if (req_i[i]) idx_c_o = irq_idx_t'(i);
      end
   end

endmodule

// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller driving the CPU's single IRQ line.
// Source edges latch into pending bits, pending & mask drives irq, and the
// ID register reports the highest-priority enabled pending source.
//  clk, rst_n : clock, asynchronous active-low reset
//  src        : interrupt sources (synchronous to clk)
//  cs, we     : register select and write strobe
//  addr       : register offset (STATUS, MASK, ID, CFG)
//  wdata      : CPU write data
//  rdata      : registered read data
//  irq        : registered active-high interrupt request
// Optional feature: define IRQ_CTRL_LEVEL_EN for per-source level mode via CFG.
module irq_ctrl
   import irq_ctrl_pkg::*;
#(
   parameter int unsigned NSRC = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NSRC-1:0] src,
   input  logic            cs,
   input  logic            we,
   input  logic [1:0]      addr,
   input  logic [7:0]      wdata,
   output logic [7:0]      rdata,
   output logic            irq
);

   logic [NSRC-1:0] src_q;
   logic [NSRC-1:0] pending_q, pending_d;
   logic [NSRC-1:0] mask_q, mask_d;
   logic [NSRC-1:0] cfg_q;
   logic [7:0]      rdata_q, rdata_d;
   logic            irq_q, irq_d;

   logic            id_valid;
   irq_idx_t        id_idx;
   logic [7:0]      id_val;
   logic [NSRC-1:0] set_ev;
   logic [NSRC-1:0] w1c;
   logic            wr_en, rd_en;
   logic            unused_wdata;

   // Upper write-data bits are ignored when NSRC < 8.
   assign unused_wdata = ^wdata;

   assign wr_en = cs & we;
   assign rd_en = cs & ~we;

   irq_prio_enc #(.NSRC(NSRC)) u_prio_enc (
      .req_i     (pending_q & mask_q),
      .valid_c_o (id_valid),
      .idx_c_o   (id_idx)
   );

   always_comb begin
      id_val               = '0;
      id_val[ID_VALID_BIT] = id_valid;
      id_val[2:0]          = id_idx;
   end

`ifdef IRQ_CTRL_LEVEL_EN
   logic [NSRC-1:0] cfg_d;

   // Level sources re-set pending every cycle they are high.
   assign set_ev = (src & ~src_q) | (src & cfg_q);

   always_comb begin
      cfg_d = cfg_q;
      if (wr_en && addr == REG_CFG) cfg_d = wdata[NSRC-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cfg_q <= '0;
      else        cfg_q <= cfg_d;
   end
`else
   assign set_ev = src & ~src_q;
   assign cfg_q  = '0;
`endif

   // Next-state: set events win over a simultaneous W1C.
   always_comb begin
      w1c       = '0;
      mask_d    = mask_q;
      rdata_d   = rdata_q;
      if (wr_en && addr == REG_STATUS) w1c    = wdata[NSRC-1:0];
      if (wr_en && addr == REG_MASK)   mask_d = wdata[NSRC-1:0];
      pending_d = (pending_q & ~w1c) | set_ev;
      irq_d     = |(pending_d & mask_d);
      if (rd_en) begin
         unique case (addr)
            REG_STATUS: rdata_d = 8'(pending_q);
            REG_MASK:   rdata_d = 8'(mask_q);
            REG_ID:     rdata_d = id_val;
            REG_CFG:    rdata_d = 8'(cfg_q);
            default:    rdata_d = '0;
         endcase
      end
   end

   // State registers; src_q resets high so sources already high at release are ignored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         src_q     <= '1;
         pending_q <= '0;
         mask_q    <= '0;
         rdata_q   <= '0;
         irq_q     <= 1'b0;
      end else begin
         src_q     <= src;
         pending_q <= pending_d;
         mask_q    <= mask_d;
         rdata_q   <= rdata_d;
         irq_q     <= irq_d;
      end
   end

   assign rdata = rdata_q;
   assign irq   = irq_q;

endmodule
